// File: rtl/sysid_pkg.sv
// Shared types and constants for the system-ID boot checker.
// Defines state encodings, word addresses, default expected words and the captured-word payload.
package sysid_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned RETRY_W = 4;
  localparam int unsigned WAIT_W  = 8;
  localparam int unsigned LAT_W   = 2;
  localparam int unsigned STATE_W = 3;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_RD_ID  = 3'd1;
  localparam state_t ST_LAT_ID = 3'd2;
  localparam state_t ST_RD_TS  = 3'd3;
  localparam state_t ST_LAT_TS = 3'd4;
  localparam state_t ST_CHECK  = 3'd5;
  localparam state_t ST_FINISH = 3'd6;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  localparam logic [DATA_W-1:0] DEF_EXPECTED_ID = 32'hACD51302;
  localparam logic [DATA_W-1:0] DEF_EXPECTED_TS = 32'h52D8FE74;

  typedef struct packed {
    logic [DATA_W-1:0] id;
    logic [DATA_W-1:0] ts;
  } sysid_words_t;

  function automatic logic words_match(input sysid_words_t w,
                                       input logic [DATA_W-1:0] exp_id,
                                       input logic [DATA_W-1:0] exp_ts);
    return (w.id == exp_id) && (w.ts == exp_ts);
  endfunction

endpackage

// File: rtl/sysid_boot_checker_if.sv
// Avalon-MM read-only link between the boot checker (master) and the sysid slave.
interface sysid_boot_checker_if;
  import sysid_pkg::*;

  logic              avm_read;
  logic              avm_address;
  logic [DATA_W-1:0] avm_readdata;
  logic              avm_waitrequest;

  modport master (
    output avm_read,
    output avm_address,
    input  avm_readdata,
    input  avm_waitrequest
  );

  modport slave (
    input  avm_read,
    input  avm_address,
    output avm_readdata,
    output avm_waitrequest
  );

endinterface

// File: rtl/sysid_avm_read_unit.sv
// Single Avalon read engine: holds the strobe until accepted, aborts on a stuck slave,
// and flags the cycle in which readdata is valid after the configured latency.
module sysid_avm_read_unit
  import sysid_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 0,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 launch_i,
  input  logic                 addr_i,
  sysid_boot_checker_if.master avm,
  output logic                 accept_c_o,
  output logic                 valid_c_o,
  output logic                 timeout_c_o
);

  logic              read_q,  read_d;
  logic              addr_q,  addr_d;
  logic [WAIT_W-1:0] wait_q,  wait_d;
  logic [LAT_W-1:0]  lat_q,   lat_d;

  assign avm.avm_read    = read_q;
  assign avm.avm_address = addr_q;

  // Strobe, stall counter and latency countdown for the one outstanding read.
  always_comb begin
    read_d = read_q;
    addr_d = addr_q;
    wait_d = wait_q;
    lat_d  = lat_q;

    accept_c_o  = read_q & ~avm.avm_waitrequest;
    timeout_c_o = read_q & avm.avm_waitrequest & (wait_q == WAIT_W'(TIMEOUT - 1));
    valid_c_o   = (READ_LATENCY == 0) ? accept_c_o : (lat_q == LAT_W'(1));

    if (lat_q != '0) begin
      lat_d = lat_q - LAT_W'(1);
    end

    if (read_q) begin
      if (!avm.avm_waitrequest) begin
        read_d = 1'b0;
        if (READ_LATENCY != 0) begin
          lat_d = LAT_W'(READ_LATENCY);
        end
      end else if (timeout_c_o) begin
        read_d = 1'b0;
      end else begin
        wait_d = wait_q + WAIT_W'(1);
      end
    end

    // A launch on the accept edge chains the next address without a bubble.
    if (launch_i) begin
      read_d = 1'b1;
      addr_d = addr_i;
      wait_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_q <= 1'b0;
      addr_q <= ADDR_ID;
      wait_q <= '0;
      lat_q  <= '0;
    end else begin
      read_q <= read_d;
      addr_q <= addr_d;
      wait_q <= wait_d;
      lat_q  <= lat_d;
    end
  end

endmodule

// File: rtl/sysid_boot_checker.sv
// Boot-time sysid verifier: reads the ID and timestamp words, compares them to build-time
// values, retries on mismatch and reports pass/timeout to status logic.
module sysid_boot_checker
  import sysid_pkg::*;
#(
  parameter logic [DATA_W-1:0] EXPECTED_ID  = DEF_EXPECTED_ID,
  parameter logic [DATA_W-1:0] EXPECTED_TS  = DEF_EXPECTED_TS,
  parameter int unsigned       READ_LATENCY = 0,
  parameter int unsigned       MAX_RETRY    = 3,
  parameter int unsigned       TIMEOUT      = 255
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  sysid_boot_checker_if.master avm,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 timeout,
  output logic [DATA_W-1:0]    id_value,
  output logic [DATA_W-1:0]    ts_value,
  output logic [RETRY_W-1:0]   retry_count
);

  state_t               state_q, state_d;
  logic                 busy_q,  busy_d;
  logic                 done_q,  done_d;
  logic                 pass_q,  pass_d;
  logic                 tmo_q,   tmo_d;
  sysid_words_t         words_q, words_d;
  logic [RETRY_W-1:0]   retry_q, retry_d;

  logic launch_c;
  logic rd_addr_c;
  logic rd_accept_c;
  logic rd_valid_c;
  logic rd_tmo_c;

  sysid_avm_read_unit #(
    .READ_LATENCY (READ_LATENCY),
    .TIMEOUT      (TIMEOUT)
  ) u_read_unit (
    .clk         (clock),
    .rst_n       (reset_n),
    .launch_i    (launch_c),
    .addr_i      (rd_addr_c),
    .avm         (avm),
    .accept_c_o  (rd_accept_c),
    .valid_c_o   (rd_valid_c),
    .timeout_c_o (rd_tmo_c)
  );

  // Sequencer: ID word, timestamp word, compare, then retry or finish.
  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pass_d    = pass_q;
    tmo_d     = tmo_q;
    words_d   = words_q;
    retry_d   = retry_q;
    launch_c  = 1'b0;
    rd_addr_c = ADDR_ID;

    case (state_q)
      ST_IDLE: begin
        // done_q still high means this is the done cycle; a start here is dropped.
        if (start && !done_q) begin
          state_d  = ST_RD_ID;
          busy_d   = 1'b1;
          pass_d   = 1'b0;
          tmo_d    = 1'b0;
          retry_d  = '0;
          launch_c = 1'b1;
        end
      end
      ST_RD_ID, ST_LAT_ID: begin
        if (rd_tmo_c) begin
          tmo_d   = 1'b1;
          pass_d  = 1'b0;
          state_d = ST_FINISH;
        end else if (rd_valid_c) begin
          words_d.id = avm.avm_readdata;
          state_d    = ST_RD_TS;
          launch_c   = 1'b1;
          rd_addr_c  = ADDR_TS;
        end else if (rd_accept_c) begin
          state_d = ST_LAT_ID;
        end
      end
      ST_RD_TS, ST_LAT_TS: begin
        if (rd_tmo_c) begin
          tmo_d   = 1'b1;
          pass_d  = 1'b0;
          state_d = ST_FINISH;
        end else if (rd_valid_c) begin
          words_d.ts = avm.avm_readdata;
          state_d    = ST_CHECK;
        end else if (rd_accept_c) begin
          state_d = ST_LAT_TS;
        end
      end
      ST_CHECK: begin
        if (words_match(words_q, EXPECTED_ID, EXPECTED_TS)) begin
          pass_d  = 1'b1;
          state_d = ST_FINISH;
        end else if (retry_q < RETRY_W'(MAX_RETRY)) begin
          retry_d  = retry_q + RETRY_W'(1);
          state_d  = ST_RD_ID;
          launch_c = 1'b1;
        end else begin
          pass_d  = 1'b0;
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      tmo_q   <= 1'b0;
      words_q <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      tmo_q   <= tmo_d;
      words_q <= words_d;
      retry_q <= retry_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign timeout     = tmo_q;
  assign id_value    = words_q.id;
  assign ts_value    = words_q.ts;
  assign retry_count = retry_q;

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Directed bench: two checkers (read latency 0 and 2), each with its own sysid slave model.
module tb_sysid_boot_checker;
  import sysid_pkg::*;

  localparam logic [31:0] EXP_ID    = 32'hACD51302;
  localparam logic [31:0] EXP_TS    = 32'h52D8FE74;
  localparam logic [31:0] BAD_ID    = 32'hDEADBEEF;
  localparam logic [31:0] IDLE_DATA = 32'h0BADF00D;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]  start_v, busy_v, done_v, pass_v, tmo_v, rd_v, addr_v;
  logic [31:0] id_v [2];
  logic [31:0] ts_v [2];
  logic [3:0]  rc_v [2];

  int unsigned bad_until [2];
  logic [31:0] ts_ret    [2];
  int unsigned wait_n    [2];
  logic        stall_ts  [2];

  int errors = 0;
  int checks = 0;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    localparam int unsigned LAT = (k == 0) ? 0 : 2;
    sysid_boot_checker_if bus ();
    int unsigned wcnt, pend, id_reads, ts_reads;
    logic [31:0] pend_data, data_c;
    logic        wr_c;

    always_comb begin
      wr_c = bus.avm_read && ((stall_ts[k] && bus.avm_address) || (wcnt < wait_n[k]));
      if (bus.avm_address) data_c = ts_ret[k];
      else                 data_c = (id_reads < bad_until[k]) ? BAD_ID : EXP_ID;
    end

    assign bus.avm_waitrequest = wr_c;
    assign bus.avm_readdata = (LAT == 0) ? ((bus.avm_read && !wr_c) ? data_c : IDLE_DATA)
                                         : ((pend == 1) ? pend_data : IDLE_DATA);
    assign rd_v[k]   = bus.avm_read;
    assign addr_v[k] = bus.avm_address;

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wcnt <= 0; pend <= 0; id_reads <= 0; ts_reads <= 0; pend_data <= '0;
      end else begin
        if (pend != 0) pend <= pend - 1;
        if (!bus.avm_read) wcnt <= 0;
        else if (wr_c) wcnt <= wcnt + 1;
        else begin
          wcnt <= 0;
          pend <= LAT;
          pend_data <= data_c;
          if (bus.avm_address) ts_reads <= ts_reads + 1;
          else                 id_reads <= id_reads + 1;
        end
      end
    end

    sysid_boot_checker #(.READ_LATENCY(LAT)) u_dut (
      .clock       (clk),
      .reset_n     (rst_n),
      .start       (start_v[k]),
      .avm         (bus),
      .busy        (busy_v[k]),
      .done        (done_v[k]),
      .pass        (pass_v[k]),
      .timeout     (tmo_v[k]),
      .id_value    (id_v[k]),
      .ts_value    (ts_v[k]),
      .retry_count (rc_v[k])
    );
  end

  // Pulses start, then counts cycles (start edge = 1) until done is seen or the budget runs out.
  task automatic run_check(input int k, input int budget, input int repulse_at,
                           output int cycles, output int ts_rd_cycles,
                           output logic [1:0] s1, output logic [1:0] s2);
    @(negedge clk);
    start_v[k] = 1'b1;
    cycles = 0; ts_rd_cycles = 0; s1 = '0; s2 = '0;
    do begin
      @(negedge clk);
      cycles++;
      start_v[k] = (cycles == repulse_at);
      if (cycles == 1) s1 = {rd_v[k], addr_v[k]};
      if (cycles == 2) s2 = {rd_v[k], addr_v[k]};
      if (rd_v[k] && addr_v[k]) ts_rd_cycles++;
    end while (!done_v[k] && cycles < budget);
    start_v[k] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_v = '0;
    repeat (3) @(negedge clk);
    checks++; if ({busy_v, done_v, pass_v, tmo_v, rd_v, addr_v} !== 12'h000) begin errors++;
      $display("FAIL reset_flags: got %h expected 000", {busy_v, done_v, pass_v, tmo_v, rd_v, addr_v}); end
    checks++; if ({id_v[0], ts_v[0], rc_v[0], id_v[1], ts_v[1], rc_v[1]} !== '0) begin errors++;
      $display("FAIL reset_values: got id=%h ts=%h rc=%0d expected zeros", id_v[0], ts_v[0], rc_v[0]); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int cyc, tsr; logic [1:0] s1, s2;
    run_check(0, 50, 0, cyc, tsr, s1, s2);
    checks++; if (done_v[0] !== 1'b1) begin errors++; $display("FAIL basic_done: got %b expected 1", done_v[0]); end
    checks++; if (cyc !== 5) begin errors++; $display("FAIL basic_latency: got %0d expected 5", cyc); end
    checks++; if (pass_v[0] !== 1'b1 || tmo_v[0] !== 1'b0) begin errors++;
      $display("FAIL basic_pass: got pass=%b tmo=%b expected 1/0", pass_v[0], tmo_v[0]); end
    checks++; if (rc_v[0] !== 4'd0) begin errors++; $display("FAIL basic_retry: got %0d expected 0", rc_v[0]); end
    checks++; if (id_v[0] !== EXP_ID || ts_v[0] !== EXP_TS) begin errors++;
      $display("FAIL basic_words: got %h/%h expected %h/%h", id_v[0], ts_v[0], EXP_ID, EXP_TS); end
    checks++; if (s1 !== 2'b10 || s2 !== 2'b11) begin errors++;
      $display("FAIL basic_bus_seq: got %b,%b expected 10,11", s1, s2); end
    checks++; if (tsr !== 1) begin errors++; $display("FAIL basic_ts_strobe: got %0d expected 1", tsr); end
    // start coinciding with the done pulse must be dropped
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    checks++; if (done_v[0] !== 1'b0 || busy_v[0] !== 1'b0 || rd_v[0] !== 1'b0) begin errors++;
      $display("FAIL done_start_ignored: got done=%b busy=%b rd=%b expected 0/0/0", done_v[0], busy_v[0], rd_v[0]); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_retry();
    int cyc, tsr; logic [1:0] s1, s2; int unsigned id0, ts0;
    id0 = g_dut[0].id_reads; ts0 = g_dut[0].ts_reads;
    bad_until[0] = id0 + 2;
    run_check(0, 60, 0, cyc, tsr, s1, s2);
    checks++; if (done_v[0] !== 1'b1 || pass_v[0] !== 1'b1) begin errors++;
      $display("FAIL retry_pass: got done=%b pass=%b expected 1/1", done_v[0], pass_v[0]); end
    checks++; if (rc_v[0] !== 4'd2) begin errors++; $display("FAIL retry_count: got %0d expected 2", rc_v[0]); end
    checks++; if (g_dut[0].id_reads - id0 !== 3 || g_dut[0].ts_reads - ts0 !== 3) begin errors++;
      $display("FAIL retry_reads: got id=%0d ts=%0d expected 3/3", g_dut[0].id_reads - id0, g_dut[0].ts_reads - ts0); end
    checks++; if (cyc !== 11) begin errors++; $display("FAIL retry_latency: got %0d expected 11", cyc); end
    bad_until[0] = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_retry_exhaust();
    int cyc, tsr, extra; logic [1:0] s1, s2; int unsigned id0, ts0;
    id0 = g_dut[0].id_reads; ts0 = g_dut[0].ts_reads;
    ts_ret[0] = 32'h0000_0000;
    run_check(0, 80, 0, cyc, tsr, s1, s2);
    checks++; if (done_v[0] !== 1'b1 || pass_v[0] !== 1'b0 || tmo_v[0] !== 1'b0) begin errors++;
      $display("FAIL exhaust_status: got done=%b pass=%b tmo=%b expected 1/0/0", done_v[0], pass_v[0], tmo_v[0]); end
    checks++; if (rc_v[0] !== 4'd3) begin errors++; $display("FAIL exhaust_retry: got %0d expected 3", rc_v[0]); end
    checks++; if (g_dut[0].id_reads - id0 !== 4 || g_dut[0].ts_reads - ts0 !== 4) begin errors++;
      $display("FAIL exhaust_reads: got id=%0d ts=%0d expected 4/4", g_dut[0].id_reads - id0, g_dut[0].ts_reads - ts0); end
    checks++; if (cyc !== 14) begin errors++; $display("FAIL exhaust_latency: got %0d expected 14", cyc); end
    extra = 0;
    repeat (4) begin @(negedge clk); if (done_v[0] || busy_v[0]) extra++; end
    checks++; if (extra !== 0) begin errors++; $display("FAIL exhaust_single_done: got %0d extra cycles expected 0", extra); end
    ts_ret[0] = EXP_TS;
  endtask

  task automatic test_timeout();
    int cyc, tsr; logic [1:0] s1, s2;
    stall_ts[0] = 1'b1;
    run_check(0, 400, 0, cyc, tsr, s1, s2);
    checks++; if (done_v[0] !== 1'b1 || tmo_v[0] !== 1'b1 || pass_v[0] !== 1'b0) begin errors++;
      $display("FAIL timeout_status: got done=%b tmo=%b pass=%b expected 1/1/0", done_v[0], tmo_v[0], pass_v[0]); end
    checks++; if (tsr !== 255) begin errors++; $display("FAIL timeout_strobe_len: got %0d expected 255", tsr); end
    checks++; if (cyc !== 258) begin errors++; $display("FAIL timeout_latency: got %0d expected 258", cyc); end
    checks++; if (rc_v[0] !== 4'd0 || rd_v[0] !== 1'b0) begin errors++;
      $display("FAIL timeout_no_retry: got rc=%0d rd=%b expected 0/0", rc_v[0], rd_v[0]); end
    stall_ts[0] = 1'b0;
    repeat (2) @(negedge clk);
    run_check(0, 50, 0, cyc, tsr, s1, s2);
    checks++; if (pass_v[0] !== 1'b1 || tmo_v[0] !== 1'b0 || cyc !== 5) begin errors++;
      $display("FAIL timeout_recover: got pass=%b tmo=%b cyc=%0d expected 1/0/5", pass_v[0], tmo_v[0], cyc); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_latency();
    int cyc, tsr; logic [1:0] s1, s2; int unsigned id0, ts0;
    id0 = g_dut[1].id_reads; ts0 = g_dut[1].ts_reads;
    wait_n[1] = 3;
    run_check(1, 80, 3, cyc, tsr, s1, s2);
    checks++; if (done_v[1] !== 1'b1 || pass_v[1] !== 1'b1 || tmo_v[1] !== 1'b0) begin errors++;
      $display("FAIL lat_status: got done=%b pass=%b tmo=%b expected 1/1/0", done_v[1], pass_v[1], tmo_v[1]); end
    checks++; if (id_v[1] !== EXP_ID || ts_v[1] !== EXP_TS) begin errors++;
      $display("FAIL lat_words: got %h/%h expected %h/%h", id_v[1], ts_v[1], EXP_ID, EXP_TS); end
    checks++; if (cyc !== 15) begin errors++; $display("FAIL lat_latency: got %0d expected 15", cyc); end
    checks++; if (tsr !== 4) begin errors++; $display("FAIL lat_ts_strobe: got %0d expected 4", tsr); end
    checks++; if (rc_v[1] !== 4'd0 || g_dut[1].id_reads - id0 !== 1 || g_dut[1].ts_reads - ts0 !== 1) begin errors++;
      $display("FAIL lat_busy_start: got rc=%0d id=%0d ts=%0d expected 0/1/1", rc_v[1], g_dut[1].id_reads - id0, g_dut[1].ts_reads - ts0); end
    repeat (2) @(negedge clk);
    checks++; if (busy_v[1] !== 1'b0) begin errors++; $display("FAIL lat_no_rerun: got busy=%b expected 0", busy_v[1]); end
    wait_n[1] = 0;
  endtask

  task automatic test_reset_mid();
    int cyc, tsr; logic [1:0] s1, s2;
    @(negedge clk); start_v[0] = 1'b1;
    @(negedge clk); start_v[0] = 1'b0;
    @(negedge clk);
    checks++; if (rd_v[0] !== 1'b1 || addr_v[0] !== 1'b1 || id_v[0] !== EXP_ID) begin errors++;
      $display("FAIL rstmid_pre: got rd=%b addr=%b id=%h expected 1/1/%h", rd_v[0], addr_v[0], id_v[0], EXP_ID); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (rd_v[0] !== 1'b0 || addr_v[0] !== 1'b0 || busy_v[0] !== 1'b0 || done_v[0] !== 1'b0) begin errors++;
      $display("FAIL rstmid_bus: got rd=%b addr=%b busy=%b done=%b expected 0", rd_v[0], addr_v[0], busy_v[0], done_v[0]); end
    checks++; if (id_v[0] !== 32'h0 || pass_v[0] !== 1'b0 || tmo_v[0] !== 1'b0 || rc_v[0] !== 4'd0) begin errors++;
      $display("FAIL rstmid_status: got id=%h pass=%b tmo=%b rc=%0d expected 0", id_v[0], pass_v[0], tmo_v[0], rc_v[0]); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    run_check(0, 50, 0, cyc, tsr, s1, s2);
    checks++; if (pass_v[0] !== 1'b1 || cyc !== 5 || ts_v[0] !== EXP_TS) begin errors++;
      $display("FAIL rstmid_rerun: got pass=%b cyc=%0d ts=%h expected 1/5/%h", pass_v[0], cyc, ts_v[0], EXP_TS); end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      bad_until[i] = 0; ts_ret[i] = EXP_TS; wait_n[i] = 0; stall_ts[i] = 1'b0;
    end
    start_v = '0;
    test_reset();
    test_basic();
    test_retry();
    test_retry_exhaust();
    test_timeout();
    test_latency();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
